// File: rtl/os_seq_pkg.sv
// Shared definitions for the output-stationary instruction sequencer.
// Holds the sequencer state enum, the bit position of every field in the
// 49-bit core instruction word, the IDLE instruction constant and the
// default phase-length parameters with helpers that derive phase lengths.
package os_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDW,
    S_G1,
    S_LDPE,
    S_G2,
    S_LDX,
    S_G3,
    S_EXEC,
    S_G4,
    S_DRN,
    S_DONE
  } state_t;

  localparam int INST_W = 49;
  localparam int ADDR_W = 11;

  // Field positions inside the instruction word
  localparam int BIT_MODE      = 48;
  localparam int BIT_RELU      = 47;
  localparam int BIT_ACC       = 46;
  localparam int BIT_CEN_WMEM  = 45;
  localparam int BIT_WEN_WMEM  = 44;
  localparam int A_WMEM_LSB    = 33;
  localparam int BIT_CEN_PMEM  = 32;
  localparam int BIT_WEN_PMEM  = 31;
  localparam int A_PMEM_LSB    = 20;
  localparam int BIT_CEN_XMEM  = 19;
  localparam int BIT_WEN_XMEM  = 18;
  localparam int A_XMEM_LSB    = 7;
  localparam int BIT_OFIFO_RD  = 6;
  localparam int BIT_IFIFO_WR  = 5;
  localparam int BIT_IFIFO_RD  = 4;
  localparam int BIT_L0_RD     = 3;
  localparam int BIT_L0_WR     = 2;
  localparam int BIT_EXECUTE   = 1;
  localparam int BIT_LOAD      = 0;

  // All memories disabled (CEN/WEN high), every strobe low
  localparam logic [INST_W-1:0] IDLE_INST =
      (49'd1 << BIT_CEN_WMEM) | (49'd1 << BIT_WEN_WMEM) |
      (49'd1 << BIT_CEN_PMEM) | (49'd1 << BIT_WEN_PMEM) |
      (49'd1 << BIT_CEN_XMEM) | (49'd1 << BIT_WEN_XMEM);

  // Default array geometry and pass shape
  localparam int               DEF_ROW     = 8;
  localparam int               DEF_COL     = 8;
  localparam int               DEF_LEN_NIJ = 36;
  localparam int               DEF_GAP     = 10;
  localparam int               DEF_ADDR_BW = 11;
  localparam logic [10:0]      DEF_W_BASE  = 11'h400;

  // Number of cycles the sequencer stays in a given phase
  function automatic int phaseLen(state_t s, int r, int c, int n, int g);
    case (s)
      S_LDW, S_LDPE:           return c;
      S_G1, S_G2, S_G3, S_G4:  return g;
      S_LDX:                   return n;
      S_EXEC:                  return n + r + c;
      S_DRN:                   return n + 1;
      default:                 return 1;
    endcase
  endfunction

  // Total cycles spent on one kernel position
  function automatic int kijCycles(int r, int c, int n, int g);
    return 2 * c + 4 * g + 3 * n + r + c + 1;
  endfunction

endpackage

// File: rtl/os_inst_pack.sv
// Combinational packer for the 49-bit core instruction word.
// Ports:
//   mode_i, relu_i, acc_i            : control bits [48:46]
//   cenPmem_i, wenPmem_i, aPmem_i    : psum memory enable/write/address
//   cenXmem_i, wenXmem_i, aXmem_i    : activation/weight memory controls
//   ofifoRd_i, l0Rd_i, l0Wr_i,
//   execute_i, load_i                : datapath strobes
//   inst_o                           : packed instruction word
// The wmem and ififo fields are never used by this sequencer and are
// always driven to their idle values.
module os_inst_pack
  import os_seq_pkg::*;
(
  input  logic              mode_i,
  input  logic              relu_i,
  input  logic              acc_i,
  input  logic              cenPmem_i,
  input  logic              wenPmem_i,
  input  logic [ADDR_W-1:0] aPmem_i,
  input  logic              cenXmem_i,
  input  logic              wenXmem_i,
  input  logic [ADDR_W-1:0] aXmem_i,
  input  logic              ofifoRd_i,
  input  logic              l0Rd_i,
  input  logic              l0Wr_i,
  input  logic              execute_i,
  input  logic              load_i,
  output logic [INST_W-1:0] inst_o
);

  // Start from the idle word so unused fields stay parked, then overlay
  // every field this sequencer actually drives.
  always_comb begin
    inst_o                            = IDLE_INST;
    inst_o[BIT_MODE]                  = mode_i;
    inst_o[BIT_RELU]                  = relu_i;
    inst_o[BIT_ACC]                   = acc_i;
    inst_o[BIT_CEN_PMEM]              = cenPmem_i;
    inst_o[BIT_WEN_PMEM]              = wenPmem_i;
    inst_o[A_PMEM_LSB +: ADDR_W]      = aPmem_i;
    inst_o[BIT_CEN_XMEM]              = cenXmem_i;
    inst_o[BIT_WEN_XMEM]              = wenXmem_i;
    inst_o[A_XMEM_LSB +: ADDR_W]      = aXmem_i;
    inst_o[BIT_OFIFO_RD]              = ofifoRd_i;
    inst_o[BIT_L0_RD]                 = l0Rd_i;
    inst_o[BIT_L0_WR]                 = l0Wr_i;
    inst_o[BIT_EXECUTE]               = execute_i;
    inst_o[BIT_LOAD]                  = load_i;
  end

endmodule

// File: rtl/os_inst_seq.sv
// Output-stationary instruction sequencer. Walks every kernel position of a
// convolution pass through weight L0 fill, PE weight load, activation L0
// fill, execution and OFIFO drain, emitting one registered core instruction
// per cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : pass request, honoured only while idle
//   kij_num       : number of kernel positions (0 finishes immediately)
//   mode, relu    : captured at start, driven on inst[48:47] while busy
//   busy, done    : pass in flight / one-cycle completion pulse
//   kij_idx       : kernel position currently being issued
//   inst          : registered 49-bit instruction word
//   busy_cycles   : busy-cycle counter, present only with OS_INST_SEQ_PERF_EN
module os_inst_seq
  import os_seq_pkg::*;
#(
  parameter int               row     = DEF_ROW,
  parameter int               col     = DEF_COL,
  parameter int               len_nij = DEF_LEN_NIJ,
  parameter int               gap     = DEF_GAP,
  parameter int               addr_bw = DEF_ADDR_BW,
  parameter logic [addr_bw-1:0] w_base = DEF_W_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        kij_num,
  input  logic              mode,
  input  logic              relu,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx,
  output logic [INST_W-1:0] inst
`ifdef OS_INST_SEQ_PERF_EN
  ,
  output logic [15:0]       busy_cycles
`endif
);

  localparam int CNT_W = 16;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          kij_q, kij_d;
  logic [3:0]          num_q, num_d;
  logic [addr_bw-1:0]  pptr_q, pptr_d;
  logic                mode_q, mode_d;
  logic                relu_q, relu_d;
  logic [INST_W-1:0]   inst_q, instD;
  logic                busy_q, done_q;
  logic                accept;
  logic                phaseEnd;
  logic [31:0]         phLast;

  logic                accBit, cenP, wenP, cenX, wenX;
  logic                ofifoRd, l0Rd, l0Wr, execBit, loadBit;
  logic [ADDR_W-1:0]   aP, aX;

  assign accept   = (state_q == S_IDLE) && start;
  assign phLast   = 32'(phaseLen(state_q, row, col, len_nij, gap) - 1);
  assign phaseEnd = (32'(cnt_q) == phLast);

  // Next-state logic. The instruction register is loaded from the next
  // state so that the word for a phase appears the same cycle the phase is
  // entered, giving one cycle from start to the first weight-fill word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    kij_d   = kij_q;
    num_d   = num_q;
    pptr_d  = pptr_q;
    mode_d  = mode_q;
    relu_d  = relu_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        kij_d = '0;
        if (start) begin
          mode_d  = mode;
          relu_d  = relu;
          num_d   = kij_num;
          pptr_d  = '0;
          state_d = (kij_num == 4'd0) ? S_DONE : S_LDW;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        kij_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        if (phaseEnd) begin
          cnt_d = '0;
          case (state_q)
            S_LDW:  state_d = S_G1;
            S_G1:   state_d = S_LDPE;
            S_LDPE: state_d = S_G2;
            S_G2:   state_d = S_LDX;
            S_LDX:  state_d = S_G3;
            S_G3:   state_d = S_EXEC;
            S_EXEC: state_d = S_G4;
            S_G4:   state_d = S_DRN;
            default: begin
              if (({1'b0, kij_q} + 5'd1) < {1'b0, num_q}) begin
                kij_d   = kij_q + 4'd1;
                state_d = S_LDW;
              end else begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
    endcase
    // The psum pointer advances once for every drain word issued and is
    // deliberately kept across kernel positions.
    if (state_d == S_DRN) begin
      pptr_d = pptr_q + addr_bw'(1);
    end
  end

  // Strobe decode for the word about to be registered
  always_comb begin
    accBit  = 1'b0;
    cenP    = 1'b1;
    wenP    = 1'b1;
    aP      = '0;
    cenX    = 1'b1;
    wenX    = 1'b1;
    aX      = '0;
    ofifoRd = 1'b0;
    l0Rd    = 1'b0;
    l0Wr    = 1'b0;
    execBit = 1'b0;
    loadBit = 1'b0;
    case (state_d)
      S_LDW: begin
        cenX = 1'b0;
        l0Wr = 1'b1;
        aX   = ADDR_W'(32'(w_base) + 32'(kij_d) * 32'(col) + 32'(cnt_d));
      end
      S_LDPE: begin
        l0Rd    = 1'b1;
        loadBit = 1'b1;
      end
      S_LDX: begin
        cenX = 1'b0;
        l0Wr = 1'b1;
        aX   = ADDR_W'(cnt_d);
      end
      S_EXEC: begin
        l0Rd    = 1'b1;
        execBit = 1'b1;
      end
      S_DRN: begin
        ofifoRd = 1'b1;
        cenP    = 1'b0;
        wenP    = 1'b0;
        aP      = ADDR_W'(pptr_q);
        accBit  = (kij_d != 4'd0);
      end
      default: ;
    endcase
  end

  os_inst_pack u_pack (
    .mode_i    ((state_d != S_IDLE) ? mode_d : 1'b0),
    .relu_i    ((state_d != S_IDLE) ? relu_d : 1'b0),
    .acc_i     (accBit),
    .cenPmem_i (cenP),
    .wenPmem_i (wenP),
    .aPmem_i   (aP),
    .cenXmem_i (cenX),
    .wenXmem_i (wenX),
    .aXmem_i   (aX),
    .ofifoRd_i (ofifoRd),
    .l0Rd_i    (l0Rd),
    .l0Wr_i    (l0Wr),
    .execute_i (execBit),
    .load_i    (loadBit),
    .inst_o    (instD)
  );

  // State and output registers. Reset drops straight to IDLE so no
  // partially issued phase ever completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      num_q   <= '0;
      pptr_q  <= '0;
      mode_q  <= 1'b0;
      relu_q  <= 1'b0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      num_q   <= num_d;
      pptr_q  <= pptr_d;
      mode_q  <= mode_d;
      relu_q  <= relu_d;
      inst_q  <= instD;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign inst    = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign kij_idx = kij_q;

`ifdef OS_INST_SEQ_PERF_EN
  logic [15:0] busyCnt_q;

  // Saturating count of busy cycles, restarted by each accepted pass and
  // frozen once the pass has finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCnt_q <= '0;
    end else if (accept) begin
      busyCnt_q <= '0;
    end else if (busy_q && (busyCnt_q != 16'hFFFF)) begin
      busyCnt_q <= busyCnt_q + 16'd1;
    end
  end

  assign busy_cycles = busyCnt_q;
`endif

endmodule
